imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface that the fetch stage reads.

---
 rtl/loader_pkg.sv | 16 +
 rtl/imem_word_assembler.sv | 57 +++++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted payload bytes (LSB first) into 32-bit words and emits a
// registered one-cycle write strobe with the completed word.
module imem_word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_accept,
    input  logic [7:0]              i_byte,
    output logic                    o_last_byte,
    output logic                    o_word_complete,
    output logic [P_DATA_WIDTH-1:0] o_word
);

    logic [1:0]              idx_q, idx_d;
    // Only b0..b2 need holding; b3 is merged straight into the output word.
    logic [P_DATA_WIDTH-9:0] byte_sr_q, byte_sr_d;
    logic                    word_complete_q, word_complete_d;
    logic [P_DATA_WIDTH-1:0] word_q, word_d;

    assign o_last_byte     = i_accept && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign o_word_complete = word_complete_q;
    assign o_word          = word_q;

    always_comb begin
        idx_d           = idx_q;
        byte_sr_d       = byte_sr_q;
        word_complete_d = 1'b0;
        word_d          = word_q;
        if (i_accept) begin
            idx_d = idx_q + 2'd1;
            if (o_last_byte) begin
                word_complete_d = 1'b1;
                word_d          = {i_byte, byte_sr_q};
            end else begin
                byte_sr_d = {i_byte, byte_sr_q[P_DATA_WIDTH-9:8]};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q           <= '0;
            byte_sr_q       <= '0;
            word_complete_q <= 1'b0;
            word_q          <= '0;
        end else begin
            idx_q           <= idx_d;
            byte_sr_q       <= byte_sr_d;
            word_complete_q <= word_complete_d;
            word_q          <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader writing imem and holding the core in reset until done.
// Optional trailing XOR checksum byte is built when LOADER_CHECKSUM_EN is defined.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_ADDR_WIDTH = 10,
    parameter int unsigned P_LEN_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_byte_valid,
    input  logic [7:0]              i_byte_data,
    output logic                    o_byte_ready,
    input  logic                    i_load_req,
    output logic                    o_imem_we,
    output logic [P_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [P_DATA_WIDTH-1:0] o_imem_wdata,
    output logic                    o_core_rst_n,
    output logic                    o_done,
    output logic                    o_error,
    output logic [P_LEN_WIDTH-1:0]  o_words_written
);

    localparam int unsigned CAP_W = ((P_LEN_WIDTH > P_ADDR_WIDTH) ? P_LEN_WIDTH : P_ADDR_WIDTH) + 1;
    localparam logic [CAP_W-1:0] CAPACITY = CAP_W'(1) << P_ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t PAYLOAD_END = S_CHK;
`else
    localparam loader_state_t PAYLOAD_END = S_DONE;
`endif

    loader_state_t                  state_q, state_d;
    logic [8*(LEN_BYTES-1)-1:0]     len_lo_q, len_lo_d;
    logic [P_LEN_WIDTH-1:0]         n_q, n_d;
    logic [P_LEN_WIDTH-1:0]         wcnt_q, wcnt_d;
    logic [P_LEN_WIDTH-1:0]         ww_q, ww_d;
    logic [P_ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                     chk_q, chk_d;
`endif

    logic                           accept;
    logic                           asm_last;
    logic [P_LEN_WIDTH-1:0]         n_hdr;

    assign o_byte_ready    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                             (state_q == S_DATA)   || (state_q == S_CHK);
    assign accept          = i_byte_valid && o_byte_ready;
    assign n_hdr           = P_LEN_WIDTH'({i_byte_data, len_lo_q});
    assign o_imem_addr     = addr_q;
    assign o_words_written = ww_q;
    assign o_done          = done_q;
    assign o_error         = err_q;
    assign o_core_rst_n    = done_q;

    imem_word_assembler #(
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_asm (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_accept        (accept && (state_q == S_DATA)),
        .i_byte          (i_byte_data),
        .o_last_byte     (asm_last),
        .o_word_complete (o_imem_we),
        .o_word          (o_imem_wdata)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        ww_d     = ww_q;
        addr_d   = addr_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d    = chk_q;
`endif

        // Address advances after each write but parks on the last word of the image.
        if (o_imem_we) begin
            ww_d = ww_q + P_LEN_WIDTH'(1);
            if ((ww_q + P_LEN_WIDTH'(1)) != n_q) begin
                addr_d = addr_q + P_ADDR_WIDTH'(1);
            end
        end

        case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = i_byte_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    n_d = n_hdr;
                    if (n_hdr == '0) begin
                        state_d = PAYLOAD_END;
                    end else if (CAP_W'(n_hdr) > CAPACITY) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ i_byte_data;
`endif
                    if (asm_last) begin
                        wcnt_d = wcnt_q + P_LEN_WIDTH'(1);
                        if ((wcnt_q + P_LEN_WIDTH'(1)) == n_q) begin
                            state_d = PAYLOAD_END;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (i_byte_data == chk_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (i_load_req) begin
                    state_d = S_LEN_LO;
                    n_d     = '0;
                    wcnt_d  = '0;
                    ww_d    = '0;
                    addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            default: state_d = S_LEN_LO;
        endcase

        // Hold o_done off while the final word's write strobe is still pending.
        done_d = (state_d == S_DONE) && !asm_last;
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_LEN_LO;
            len_lo_q <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            ww_q     <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            ww_q     <= ww_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader (capacity 16 words) with a byte-level image model.
module tb_imem_loader;
    localparam int AW  = 4;
    localparam int LW  = 16;
    localparam int DW  = 32;
    localparam int CAP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [7:0]    bdata = 8'h00;
    logic          load_req = 1'b0;
    logic          byte_ready, imem_we, core_rst_n, done, error;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [LW-1:0] words_written;

    imem_loader #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW),
        .P_LEN_WIDTH  (LW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_byte_valid    (valid),
        .i_byte_data     (bdata),
        .o_byte_ready    (byte_ready),
        .i_load_req      (load_req),
        .o_imem_we       (imem_we),
        .o_imem_addr     (imem_addr),
        .o_imem_wdata    (imem_wdata),
        .o_core_rst_n    (core_rst_n),
        .o_done          (done),
        .o_error         (error),
        .o_words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            gap_pct = 0;
    wr_t           exp_q[$];
    logic [AW-1:0] log_a[$];
    logic [31:0]   log_d[$];
    logic [31:0]   img[CAP+2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every write the DUT makes must be the next one the image model predicts.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                log_a.push_back(imem_addr);
                log_d.push_back(imem_wdata);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(imem_we), 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(imem_addr), 64'(e.a));
                    check("wr_data", 64'(imem_wdata), 64'(e.d));
                end
            end
            check("core_rst_n_tracks_done", 64'(core_rst_n), 64'(done));
            if (done) check("done_with_pending_writes", 64'(exp_q.size()), 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int budget;
        budget = 50;
        ok = 1'b0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) tick();
        valid = 1'b1;
        bdata = b;
        while (budget > 0) begin
            if (byte_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
            budget--;
        end
        valid = 1'b0;
        bdata = 8'($urandom);
    endtask

    task automatic wait_outcome();
        for (int i = 0; i < 60 && !(done || error); i++) tick();
    endtask

    task automatic run_image(input int n, input bit bad_chk);
        bit         ok;
        bit         exp_ok;
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] nn;
        wr_t        e;
        x = 8'h00;
        nn = 16'(n);
        log_a.delete();
        log_d.delete();
        send_byte(nn[7:0], ok);
        send_byte(nn[15:8], ok);
        check("len_accepted", 64'(ok), 64'd1);
        if (n > CAP) begin
            wait_outcome();
            check("overlen_error", 64'(error), 64'd1);
            check("overlen_done", 64'(done), 64'd0);
            check("overlen_ready", 64'(byte_ready), 64'd0);
            check("overlen_core_rst_n", 64'(core_rst_n), 64'd0);
            check("overlen_words", 64'(words_written), 64'd0);
        end else begin
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < 4; k++) begin
                    b = img[w][8*k +: 8];
                    x = x ^ b;
                    send_byte(b, ok);
                    if (k == 3) begin
                        e.a = AW'(w);
                        e.d = img[w];
                        exp_q.push_back(e);
                    end
                end
            end
            exp_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_chk ? 8'h00 : x, ok);
            if (bad_chk) exp_ok = (x == 8'h00);
`else
            if (bad_chk) exp_ok = 1'b1;
`endif
            wait_outcome();
            tick();
            check("done", 64'(done), 64'(exp_ok));
            check("error", 64'(error), 64'(!exp_ok));
            check("core_rst_n", 64'(core_rst_n), 64'(exp_ok));
            check("words_written", 64'(words_written), 64'(n));
            check("ready_after_load", 64'(byte_ready), 64'd0);
            check("write_count", 64'(log_a.size()), 64'(n));
        end
    endtask

    task automatic restart();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("restart_done", 64'(done), 64'd0);
        check("restart_error", 64'(error), 64'd0);
        check("restart_words", 64'(words_written), 64'd0);
        check("restart_addr", 64'(imem_addr), 64'd0);
        check("restart_ready", 64'(byte_ready), 64'd1);
    endtask

    task automatic two_word_image();
        img[0] = 32'h12345678;
        img[1] = 32'hDEADBEEF;
    endtask

    initial begin
        bit ok;
        int n;
        logic [7:0] b;
        wr_t e;

        repeat (3) tick();
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_ready", 64'(byte_ready), 64'd1);
        rst = 1'b0;
        tick();

        two_word_image();
        run_image(2, 1'b0);
        check("lit_addr0", 64'(log_a[0]), 64'h0);
        check("lit_data0", 64'(log_d[0]), 64'h12345678);
        check("lit_addr1", 64'(log_a[1]), 64'h1);
        check("lit_data1", 64'(log_d[1]), 64'hDEADBEEF);
        check("lit_words", 64'(words_written), 64'd2);

        restart();
        run_image(0, 1'b0);

        restart();
        run_image(17, 1'b0);
        check("overlen_no_writes", 64'(log_a.size()), 64'd0);

        restart();
        for (int w = 0; w < CAP; w++) img[w] = $urandom;
        run_image(16, 1'b0);
        check("full_last_addr", 64'(log_a[15]), 64'd15);
        check("full_addr_parked", 64'(imem_addr), 64'd15);

`ifdef LOADER_CHECKSUM_EN
        restart();
        two_word_image();
        run_image(2, 1'b1);
        restart();
        run_image(2, 1'b0);
`endif

        restart();
        gap_pct = 30;
        two_word_image();
        run_image(2, 1'b0);
        check("gap_data0", 64'(log_d[0]), 64'h12345678);
        check("gap_data1", 64'(log_d[1]), 64'hDEADBEEF);

        for (int it = 0; it < 8; it++) begin
            restart();
            n = $urandom_range(0, CAP + 1);
            for (int w = 0; w < CAP; w++) img[w] = $urandom;
            run_image(n, 1'b0);
        end

        // Abort a load after 5 payload bytes with an asynchronous reset.
        restart();
        gap_pct = 0;
        two_word_image();
        send_byte(8'h02, ok);
        send_byte(8'h00, ok);
        for (int k = 0; k < 5; k++) begin
            b = (k < 4) ? img[0][8*k +: 8] : img[1][7:0];
            send_byte(b, ok);
            if (k == 3) begin
                e.a = '0;
                e.d = img[0];
                exp_q.push_back(e);
            end
        end
        rst = 1'b1;
        #1;
        check("abort_we", 64'(imem_we), 64'd0);
        check("abort_addr", 64'(imem_addr), 64'd0);
        check("abort_wdata", 64'(imem_wdata), 64'd0);
        check("abort_core_rst_n", 64'(core_rst_n), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_error", 64'(error), 64'd0);
        check("abort_words", 64'(words_written), 64'd0);
        check("abort_word0_written", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        run_image(2, 1'b0);
        check("reload_addr0", 64'(log_a[0]), 64'h0);
        check("reload_data1", 64'(log_d[1]), 64'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
